// File: rtl/soc_system_pio_gen2.sv
// -----------------------------------------------------------------------------
// soc_system_pio_gen2
//
// Parametrised Avalon-MM general-purpose I/O slave for the HPS-to-FPGA
// lightweight bridge. It provides the following features:
//   - an output data register with a per-bit direction register;
//   - synchronised inputs;
//   - an edge-capture register with a per-bit interrupt mask and a level irq.
//
// Optional feature (macro PIO_SET_CLEAR_EN):
//   - defined   : addr 4 (OUTSET) ORs the write data into out_port, and
//                 addr 5 (OUTCLEAR) clears the write data bits from out_port.
//   - undefined : no set/clear logic is built, and writes to addr 4/5 are ignored.
//
// Parameters:
//   DATA_WIDTH  (1..32)  I/O width in bits
//   RESET_VALUE          reset value of out_port
//   EDGE_TYPE            0 = rising, 1 = falling, 2 = any edge sets a capture bit
//   SYNC_STAGES (2..4)   input synchroniser depth
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   address, chipselect,
//   write_n, writedata      Avalon-MM slave write side (write = cs && !write_n)
//   readdata                combinational read data, zero-extended to 32 bits
//   in_port                 asynchronous external inputs
//   out_port, out_oe        output data and per-bit output enable (1 = output)
//   irq                     registered level interrupt
//
// Register map (word addresses):
//   0 DATA (wr: out_port, rd: in_sync)   1 DIRECTION   2 IRQ_MASK
//   3 EDGE_CAPTURE (write-1-to-clear)    4 OUTSET      5 OUTCLEAR   6,7 reserved
// -----------------------------------------------------------------------------
module soc_system_pio_gen2 #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] out_oe,
    output logic                  irq
);

    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int CW        = $clog2(PRIME_MAX + 1);

    logic [DATA_WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] prev_reg;
    logic [DATA_WIDTH-1:0] out_reg, out_next;
    logic [DATA_WIDTH-1:0] oe_reg;
    logic [DATA_WIDTH-1:0] mask_reg;
    logic [DATA_WIDTH-1:0] cap_reg, cap_next;
    logic [DATA_WIDTH-1:0] edge_raw, edge_bits, w1c;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [CW-1:0]         prime_cnt_reg;
    logic                  primed;
    logic                  irq_reg;
    logic                  wr;
    logic                  unused_wd;

    assign wr        = chipselect && !write_n;
    assign wd        = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;

    // ---------------- input synchroniser ----------------
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_reg[gi] <= '0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= in_port;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign in_sync = sync_reg[SYNC_STAGES-1];

    // ---------------- edge detection ----------------
    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_raw = in_sync & ~prev_reg;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_raw = ~in_sync & prev_reg;
        end else begin : g_any
            assign edge_raw = in_sync ^ prev_reg;
        end
    endgenerate

    // Until the synchroniser and prev flops have been filled with real input
    // samples, the 0 -> level transitions are reset artefacts. Those transitions
    // must not raise capture bits.
    assign primed    = (prime_cnt_reg == CW'(PRIME_MAX));
    assign edge_bits = primed ? edge_raw : '0;

    assign w1c = (wr && address == 3'd3) ? wd : '0;

    // A new edge wins over a simultaneous write-1-to-clear on the same bit.
    assign cap_next = (cap_reg & ~w1c) | edge_bits;

    always_comb begin
        out_next = out_reg;
        if (wr) begin
            case (address)
                3'd0: out_next = wd;
`ifdef PIO_SET_CLEAR_EN
                3'd4: out_next = out_reg | wd;
                3'd5: out_next = out_reg & ~wd;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg      <= '0;
            out_reg       <= RESET_VALUE;
            oe_reg        <= '0;
            mask_reg      <= '0;
            cap_reg       <= '0;
            irq_reg       <= 1'b0;
            prime_cnt_reg <= '0;
        end else begin
            prev_reg <= in_sync;
            out_reg  <= out_next;
            cap_reg  <= cap_next;
            irq_reg  <= |(cap_reg & mask_reg);
            if (wr && address == 3'd1) oe_reg   <= wd;
            if (wr && address == 3'd2) mask_reg <= wd;
            if (!primed) prime_cnt_reg <= prime_cnt_reg + 1'b1;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        rd_val = '0;
        case (address)
            3'd0:    rd_val = in_sync;
            3'd1:    rd_val = oe_reg;
            3'd2:    rd_val = mask_reg;
            3'd3:    rd_val = cap_reg;
            default: rd_val = '0;
        endcase
        readdata                   = '0;
        readdata[DATA_WIDTH-1:0]   = rd_val;
    end

    assign out_port = out_reg;
    assign out_oe   = oe_reg;
    assign irq      = irq_reg;

endmodule

// File: tb/tb_soc_system_pio_gen2.sv
// -----------------------------------------------------------------------------
// Self-checking bench for soc_system_pio_gen2 (DATA_WIDTH=8, RESET_VALUE=8'hA5,
// rising-edge capture, two synchroniser stages). The reference model keeps a
// short history of the input sampled at every clock edge since reset release.
// It derives in_sync and edges from the age of the samples, and applies the
// register-map rules once per clock.
// -----------------------------------------------------------------------------
module tb_soc_system_pio_gen2;

    localparam int         DW = 8;
    localparam logic [7:0] RV = 8'hA5;
    localparam int         ET = 0;
    localparam int         SS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  out_oe;
    logic        irq;

    soc_system_pio_gen2 #(
        .DATA_WIDTH (DW),
        .RESET_VALUE(RV),
        .EDGE_TYPE  (ET),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .out_oe    (out_oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_out, m_oe, m_mask, m_cap;
    logic       m_irq;
    logic [7:0] hist[$];   // input samples taken at each clock edge since release
    int         edges;     // clock edges since reset release
    logic [7:0] cur_in;

    function automatic logic [7:0] past(input int k);
        if (hist.size() >= k) return hist[hist.size()-k];
        return 8'h00;
    endfunction

    function automatic logic [7:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return past(SS);
            3'd1:    return m_oe;
            3'd2:    return m_mask;
            3'd3:    return m_cap;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_out = RV; m_oe = 0; m_mask = 0; m_cap = 0; m_irq = 0;
        hist.delete();
        edges = 0;
    endtask

    task automatic model_edge(input logic [7:0] inp, input logic cs, input logic wn,
                              input logic [2:0] a, input logic [31:0] d);
        logic [7:0] s, p, ev, clr;
        logic       wr, irq_n;
        s = past(SS);
        p = past(SS + 1);
        case (ET)
            0:       ev = s & ~p;
            1:       ev = ~s & p;
            default: ev = s ^ p;
        endcase
        if (edges < SS + 1) ev = 8'h00;
        wr    = cs && !wn;
        irq_n = |(m_cap & m_mask);
        clr   = (wr && a == 3'd3) ? d[7:0] : 8'h00;
        m_cap = (m_cap & ~clr) | ev;
        if (wr) begin
            case (a)
                3'd0: m_out  = d[7:0];
                3'd1: m_oe   = d[7:0];
                3'd2: m_mask = d[7:0];
`ifdef PIO_SET_CLEAR_EN
                3'd4: m_out  = m_out | d[7:0];
                3'd5: m_out  = m_out & ~d[7:0];
`endif
                default: ;
            endcase
        end
        m_irq = irq_n;
        hist.push_back(inp);
        if (hist.size() > 8) void'(hist.pop_front());
        edges++;
    endtask

    // One bus cycle: check outputs, drive inputs, check read data, clock once.
    task automatic step(input logic cs, input logic wn, input logic [2:0] a,
                        input logic [31:0] d);
        @(negedge clk);
        chk("out_port", {24'h0, out_port}, {24'h0, m_out});
        chk("out_oe",   {24'h0, out_oe},   {24'h0, m_oe});
        chk("irq",      {31'h0, irq},      {31'h0, m_irq});
        in_port = cur_in; chipselect = cs; write_n = wn; address = a; writedata = d;
        #1;
        chk($sformatf("read_a%0d", a), readdata, {24'h0, model_read(a)});
        @(posedge clk);
        model_edge(cur_in, cs, wn, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, 1'b1, a, 32'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    initial begin
        logic [31:0] r;
        reset = 1'b1; chipselect = 0; write_n = 1; address = 0; writedata = 0;
        cur_in = 8'hFF; in_port = cur_in;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_port", {24'h0, out_port}, 32'hA5);
        chk("rst_out_oe",   {24'h0, out_oe},   32'h0);
        chk("rst_irq",      {31'h0, irq},      32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // Inputs high through reset must not raise capture bits.
        repeat (10) rd(3'd3);
        #1 chk("prime_cap", readdata, 32'h0);

        cur_in = 8'h3C;
        repeat (SS + 1) rd(3'd0);
        #1 chk("data_3c", readdata, 32'h3C);

        // Rising edge on bit0 with mask bit0 set.
        cur_in = 8'h00;
        repeat (4) rd(3'd3);
        wr(3'd2, 32'h01);
        cur_in = 8'h01;
        repeat (SS + 1) rd(3'd3);
        #1 chk("cap_bit0", readdata, 32'h01);
        rd(3'd3);
        #1 chk("irq_set", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h01);
        rd(3'd3);
        #1 chk("irq_clr", {31'h0, irq}, 32'h0);

        // W1C of bit2 in the same cycle as a new bit2 edge: the edge wins.
        cur_in = 8'h05;
        repeat (SS + 1) rd(3'd3);
        cur_in = 8'h01;
        repeat (SS + 2) rd(3'd3);
        cur_in = 8'h05;
        repeat (SS) rd(3'd3);
        wr(3'd3, 32'h04);
        #1 chk("w1c_vs_edge", readdata & 32'h4, 32'h4);

        // Atomic set/clear.
        wr(3'd0, 32'h0F);
        wr(3'd4, 32'hF0);
`ifdef PIO_SET_CLEAR_EN
        #1 chk("outset", {24'h0, out_port}, 32'hFF);
`else
        #1 chk("outset", {24'h0, out_port}, 32'h0F);
`endif
        wr(3'd5, 32'h3C);
`ifdef PIO_SET_CLEAR_EN
        #1 chk("outclear", {24'h0, out_port}, 32'hC3);
`else
        #1 chk("outclear", {24'h0, out_port}, 32'h0F);
`endif

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if (r[1:0] == 2'd0) cur_in = cur_in ^ 8'($urandom);
            step(($urandom % 4) != 0, r[2], 3'($urandom_range(0, 7)), $urandom);
        end

        // Build capture = 8'h81 with irq high, then reset asynchronously.
        cur_in = 8'h00;
        wr(3'd2, 32'hFF);
        repeat (SS + 1) rd(3'd3);
        wr(3'd3, 32'hFF);
        cur_in = 8'h81;
        repeat (SS + 2) rd(3'd3);
        #1 chk("pre_rst_cap", readdata, 32'h81);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        @(negedge clk); #2;
        chipselect = 0; address = 3'd3;
        reset = 1'b1;
        #1;
        chk("async_cap", readdata, 32'h0);
        chk("async_irq", {31'h0, irq}, 32'h0);
        chk("async_out", {24'h0, out_port}, 32'hA5);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) rd(3'd3);
        #1 chk("reprime_cap", readdata, 32'h0);
        wr(3'd2, 32'h80);
        cur_in = 8'h01;
        repeat (SS + 2) rd(3'd3);
        cur_in = 8'h81;
        repeat (SS + 2) rd(3'd3);
        #1 chk("post_rst_cap", readdata, 32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
